// File: rtl/mem_pkg.sv
// Shared definitions for the byte-wide memory controller: FSM state
// encoding, client identifiers and default bus widths.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Client ids double as bit positions in the one-hot grant vector.
    localparam logic CLIENT_IC = 1'b0;
    localparam logic CLIENT_DC = 1'b1;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Two-client arbiter for mem_ctrl. Produces a one-hot grant
// (bit CLIENT_IC / bit CLIENT_DC).
// Build option MEM_CTRL_RR_ARB_EN: round-robin between the two clients
// using a last-grant register; otherwise the data cache has fixed priority
// and the arbiter is purely combinational.
module mem_arbiter
    import mem_pkg::*;
(
`ifdef MEM_CTRL_RR_ARB_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       grant_en_i,
`endif
    input  logic       ic_req_i,
    input  logic       dc_req_i,
    output logic [1:0] gnt_o
);

`ifdef MEM_CTRL_RR_ARB_EN
    logic last_q;

    // Under contention, hand the bus to whichever client was not served last.
    always_comb begin
        gnt_o = '0;
        if (ic_req_i && dc_req_i) begin
            if (last_q == CLIENT_IC) gnt_o[CLIENT_DC] = 1'b1;
            else                     gnt_o[CLIENT_IC] = 1'b1;
        end else if (dc_req_i) begin
            gnt_o[CLIENT_DC] = 1'b1;
        end else if (ic_req_i) begin
            gnt_o[CLIENT_IC] = 1'b1;
        end
    end

    // Remember who won each grant; starts as icache so dcache wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= CLIENT_IC;
        end else if (grant_en_i) begin
            last_q <= gnt_o[CLIENT_DC] ? CLIENT_DC : CLIENT_IC;
        end
    end
`else
    // Fixed priority: dcache always beats icache.
    always_comb begin
        gnt_o = '0;
        if (dc_req_i)      gnt_o[CLIENT_DC] = 1'b1;
        else if (ic_req_i) gnt_o[CLIENT_IC] = 1'b1;
    end
`endif

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide RAM controller shared by an instruction cache and a data cache.
// Every transaction takes a fixed four cycles (IDLE, BUSY, WAIT, DONE), so a
// held request is serviced once every four cycles.
// Build option MEM_CTRL_RR_ARB_EN selects round-robin arbitration in
// mem_arbiter; by default the data cache has fixed priority.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | sample requests; RAM address/data hold, ram_wr low
//  BUSY  | RAM address (and write strobe for writes) presented
//  WAIT  | RAM read data valid on ram_din
//  DONE  | done_o of the granted client high for this single cycle
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ic_request_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic [DATA_W-1:0] ic_data_o,
    output logic              ic_done_o,

    input  logic              dc_request_i,
    input  logic              dc_we_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [DATA_W-1:0] dc_data_i,
    output logic [DATA_W-1:0] dc_data_o,
    output logic              dc_done_o,

    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [DATA_W-1:0] ram_dout,
    input  logic [DATA_W-1:0] ram_din
);

    state_t state_q;
    logic   client_q;
    logic   we_q;
    logic [1:0] gnt;

`ifdef MEM_CTRL_RR_ARB_EN
    logic grant_en;

    // The last-grant register only advances when a grant is actually taken.
    always_comb begin
        grant_en = (state_q == IDLE) && (ic_request_i || dc_request_i);
    end

    mem_arbiter u_arb (
        .clk        (clk),
        .rst        (rst),
        .grant_en_i (grant_en),
        .ic_req_i   (ic_request_i),
        .dc_req_i   (dc_request_i),
        .gnt_o      (gnt)
    );
`else
    mem_arbiter u_arb (
        .ic_req_i   (ic_request_i),
        .dc_req_i   (dc_request_i),
        .gnt_o      (gnt)
    );
`endif

    // Transaction FSM; RAM strobes, done pulses and read data are registered.
    // ram_a/ram_dout double as the latched address and write byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            client_q  <= CLIENT_IC;
            we_q      <= 1'b0;
            ram_a     <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= '0;
            ic_done_o <= 1'b0;
            dc_done_o <= 1'b0;
            ic_data_o <= '0;
            dc_data_o <= '0;
        end else begin
            ram_wr    <= 1'b0;
            ic_done_o <= 1'b0;
            dc_done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt[CLIENT_DC]) begin
                        client_q <= CLIENT_DC;
                        we_q     <= dc_we_i;
                        ram_a    <= dc_addr_i;
                        ram_dout <= dc_data_i;
                        ram_wr   <= dc_we_i;
                        state_q  <= BUSY;
                    end else if (gnt[CLIENT_IC]) begin
                        client_q <= CLIENT_IC;
                        we_q     <= 1'b0;
                        ram_a    <= ic_addr_i;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A write leaves data_o untouched; only reads return a byte.
                    if (client_q == CLIENT_DC) begin
                        dc_done_o <= 1'b1;
                        if (!we_q) dc_data_o <= ram_din;
                    end else begin
                        ic_done_o <= 1'b1;
                        ic_data_o <= ram_din;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address ports.
REQ-002 Parameter DATA_W, default 8, width of every data port (byte-wide RAM).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 ic_request_i  in  1  instruction-cache read request, held until ic_done_o.
REQ-006 ic_addr_i  in  ADDR_W  instruction-cache byte address.
REQ-007 ic_data_o  out  DATA_W  byte returned to the instruction cache.
REQ-008 ic_done_o  out  1  one-cycle completion pulse to the instruction cache.
REQ-009 dc_request_i  in  1  data-cache request, held until dc_done_o.
REQ-010 dc_we_i  in  1  data-cache write enable: 1 = write, 0 = read.
REQ-011 dc_addr_i  in  ADDR_W  data-cache byte address.
REQ-012 dc_data_i  in  DATA_W  data-cache write byte.
REQ-013 dc_data_o  out  DATA_W  byte returned to the data cache.
REQ-014 dc_done_o  out  1  one-cycle completion pulse to the data cache.
REQ-015 ram_a  out  ADDR_W  RAM address, registered.
REQ-016 ram_wr  out  1  RAM write strobe, registered.
REQ-017 ram_dout  out  DATA_W  RAM write data, registered.
REQ-018 ram_din  in  DATA_W  RAM read data, valid the cycle after ram_a is driven.

Function
REQ-019 FSM states:
- IDLE -> BUSY on grant.
- BUSY -> WAIT.
- WAIT -> DONE.
- DONE -> IDLE.
REQ-020 Requests are sampled only in IDLE. On the grant edge E0 the FSM latches the granted client, address, we and write byte, and registers ram_a/ram_wr/ram_dout.
REQ-021 ram_wr is 1 for exactly the one BUSY cycle of a write transaction; it is 0 in all other cycles.
REQ-022 On edge E2 (WAIT->DONE), read data ram_din is captured into the granted client's data_o.
REQ-023 In the DONE cycle (after E2), the granted client's done_o is 1 for exactly one cycle. Writes use the same timing. Fixed latency: done 3 cycles after grant; 4 cycles per byte.
REQ-024 The non-granted client's done_o stays 0. Each data_o holds its last value until that client's next completion.
REQ-025 A request still high during DONE is not serviced until IDLE. A held request with a changed address is a new transaction, so burst fetches work as successive single-byte requests.
REQ-026 Arbitration (default): dc_request_i has fixed priority over ic_request_i when both are high in IDLE. There is no preemption of an in-flight transaction.
REQ-027 A request deasserted mid-transaction still completes; its done_o still pulses, and the requester ignores it.
REQ-028 In IDLE, ram_a and ram_dout hold their last values; ram_wr = 0.
REQ-029 Address and data pass through unmodified; no wrap or truncation, and ADDR_W is used end to end.

Reset
REQ-030 When rst is 1 at an edge: state = IDLE, ram_wr = 0, ram_a = 0, ram_dout = 0, ic_done_o = dc_done_o = 0, ic_data_o = dc_data_o = 0, last-grant register = icache.
REQ-031 Reset mid-transaction aborts it: no done pulse, and no ram_wr in the cycle after the reset edge.

Configuration
REQ-032 Macro MEM_CTRL_RR_ARB_EN.
- Defined: round-robin arbitration. When both clients request in IDLE, grant the client not granted last; a single requester is always granted.
- Undefined: fixed dcache priority per REQ-026. The last-grant register is absent.

Structure
REQ-033 Package mem_pkg holds:
- the state encoding (IDLE, BUSY, WAIT, DONE);
- client-id constants CLIENT_IC and CLIENT_DC;
- default ADDR_W and DATA_W.
REQ-034 One sub-module, mem_arbiter: request pair plus last-grant in, one-hot grant out. It is combinational except for the last-grant register under MEM_CTRL_RR_ARB_EN.

Verification
REQ-035 IC read: ic_request_i=1, ic_addr_i=0x100, RAM[0x100]=0xA5 -> ic_done_o pulses 3 cycles after grant with ic_data_o=0xA5; ram_wr stays 0.
REQ-036 DC write then read: write 0x3C to 0x2000 -> ram_wr=1 for one cycle, ram_a=0x2000, ram_dout=0x3C, dc_done_o pulses; a following read of 0x2000 returns dc_data_o=0x3C.
REQ-037 Contention: both clients request in the same IDLE cycle.
- Default build: DC is serviced first, IC completes 4 cycles later.
- MEM_CTRL_RR_ARB_EN build, sustained contention: grants alternate DC, IC, DC, IC.
REQ-038 Burst: IC holds request, stepping the address 0x0..0x3 on each done -> four done pulses spaced 4 cycles apart, each returning the correct byte.
REQ-039 rst=1 asserted in the WAIT cycle of a DC write -> no dc_done_o pulse, ram_wr=0, state IDLE; a new request after rst drops completes normally.
